score_display: RTL and testbench

Drives a 4-digit multiplexed, common-anode seven-segment display from the game's 6-bit `total_score` and `colision` outputs.
- Converts the binary score to two BCD digits with a sequential shift-add-3 converter.
- Scans the four digits round-robin.
- Blinks the display while a collision is active.
- Sits beside `game` at board top level; it is the consumer end of the score/collision status interface.

---
 rtl/display_pkg.sv | 51 +++++
 rtl/bin2bcd_seq.sv | 77 +++++++
 rtl/score_display.sv | 103 ++++++++++
 tb/tb_score_display.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and helpers for the score display.
// Contents:
//   - seven-segment glyphs, active-low, bit order {g,f,e,d,c,b,a}
//   - digit count and score width
//   - converter state type
//   - BCD adjust helper and glyph lookup
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SCORE_W    = 6;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    CONV_IDLE   = 2'd0,
    CONV_SHIFT  = 2'd1,
    CONV_COMMIT = 2'd2
  } conv_state_t;

  // Double-dabble correction applied before each shift.
  function automatic logic [3:0] bcd_adj3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 6-bit binary to two-digit BCD converter (shift-add-3).
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   bin[5:0]     value to convert, sampled when start is seen in IDLE
//   start        request a conversion (honoured only in IDLE)
//   busy         high in SHIFT and COMMIT
//   done         high for the single COMMIT cycle; tens/units are final then
//   tens[3:0]    tens nibble of the shift register
//   units[3:0]   units nibble of the shift register
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SCORE_W-1:0]  bin,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [3:0]          tens,
  output logic [3:0]          units
);

  conv_state_t state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  // {tens, units, remaining binary bits}
  logic [13:0] sr_reg, sr_next;
  logic [13:0] sr_adj;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= CONV_IDLE;
      cnt_reg   <= 3'd0;
      sr_reg    <= 14'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sr_reg    <= sr_next;
    end
  end

  assign sr_adj = {bcd_adj3(sr_reg[13:10]), bcd_adj3(sr_reg[9:6]), sr_reg[5:0]};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sr_next    = sr_reg;
    case (state_reg)
      CONV_IDLE: begin
        if (start) begin
          state_next = CONV_SHIFT;
          sr_next    = {8'b0, bin};
          cnt_next   = 3'd0;
        end
      end
      CONV_SHIFT: begin
        sr_next  = {sr_adj[12:0], 1'b0};
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == 3'd5) begin
          state_next = CONV_COMMIT;
        end
      end
      CONV_COMMIT: begin
        state_next = CONV_IDLE;
      end
      default: begin
        state_next = CONV_IDLE;
      end
    endcase
  end

  assign busy  = (state_reg != CONV_IDLE);
  assign done  = (state_reg == CONV_COMMIT);
  assign tens  = sr_reg[13:10];
  assign units = sr_reg[9:6];

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed common-anode seven-segment driver for the game score.
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   score[5:0]   binary score 0..63
//   colision     collision flag; display blinks while high
//   an[3:0]      digit anodes, active-low, an[0] = units
//   seg[6:0]     segments, active-low, {g,f,e,d,c,b,a}
//   dp           decimal point, active-low, always off
module score_display
  import display_pkg::*;
#(
  parameter int REFRESH_BITS = 16,
  parameter int BLINK_BITS   = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SCORE_W-1:0]  score,
  input  logic                colision,
  output logic [3:0]          an,
  output logic [6:0]          seg,
  output logic                dp
);

  logic [SCORE_W-1:0]      score_cap_reg;
  logic [SCORE_W-1:0]      conv_src_reg;
  logic [3:0]              tens_reg, units_reg;
  logic [REFRESH_BITS-1:0] refresh_cnt_reg;
  logic [BLINK_BITS-1:0]   blink_cnt_reg;
  logic [3:0]              an_reg, an_next;
  logic [6:0]              seg_reg, seg_next;

  logic       conv_start, conv_busy, conv_done;
  logic [3:0] conv_tens, conv_units;
  logic [1:0] digit_sel;
  logic       blank_phase;

  // A new conversion is requested only while the converter is idle; a score
  // change during a conversion is picked up once it returns to IDLE.
  assign conv_start = !conv_busy && (score_cap_reg != conv_src_reg);

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .bin   (score_cap_reg),
    .start (conv_start),
    .busy  (conv_busy),
    .done  (conv_done),
    .tens  (conv_tens),
    .units (conv_units)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_cap_reg   <= '0;
      conv_src_reg    <= '0;
      tens_reg        <= 4'd0;
      units_reg       <= 4'd0;
      refresh_cnt_reg <= '0;
      blink_cnt_reg   <= '0;
      an_reg          <= 4'b1111;
      seg_reg         <= SEG_BLANK;
    end else begin
      score_cap_reg   <= score;
      if (conv_start) begin
        conv_src_reg <= score_cap_reg;
      end
      // Display digits change only on commit, never mid-conversion.
      if (conv_done) begin
        tens_reg  <= conv_tens;
        units_reg <= conv_units;
      end
      refresh_cnt_reg <= refresh_cnt_reg + REFRESH_BITS'(1);
      blink_cnt_reg   <= colision ? (blink_cnt_reg + BLINK_BITS'(1)) : '0;
      an_reg          <= blank_phase ? 4'b1111 : an_next;
      seg_reg         <= seg_next;
    end
  end

  assign digit_sel   = refresh_cnt_reg[REFRESH_BITS-1 -: 2];
  // Gating with colision lets the display reappear the cycle it drops.
  assign blank_phase = colision && blink_cnt_reg[BLINK_BITS-1];

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign an_next[gi] = (digit_sel != 2'(gi));
    end
  endgenerate

  always_comb begin
    seg_next = SEG_BLANK;
    case (digit_sel)
      2'd0:    seg_next = seg_glyph(units_reg);
      2'd1:    seg_next = (tens_reg == 4'd0) ? SEG_BLANK : seg_glyph(tens_reg);
      default: seg_next = SEG_BLANK;
    endcase
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Testbench for score_display with a cycle-level behavioural scoreboard.
module tb_score_display;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] score = 6'd0;
  logic       colision = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  score_display #(.REFRESH_BITS(4), .BLINK_BITS(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .score    (score),
    .colision (colision),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: scan position, blink phase, and the value on display.
  // A conversion grabs the captured score when idle and it differs from the
  // last converted value, and lands on the display 7 cycles later.
  int m_scan = 0, m_blink = 0, m_cap = 0, m_src = 0, m_snap = 0, m_disp = 0, m_timer = 0;
  int d_sel;
  bit blnk;
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_seg = 7'h7F;

  always @(posedge clk) begin
    if (!reset) begin
      m_scan = 0; m_blink = 0; m_cap = 0; m_src = 0; m_snap = 0; m_disp = 0; m_timer = 0;
      e_an = 4'hF;
      e_seg = 7'h7F;
    end else begin
      d_sel = m_scan / 4;
      blnk  = colision && (m_blink >= 16);
      e_an  = 4'hF;
      if (!blnk) e_an[d_sel] = 1'b0;
      if (d_sel == 0)      e_seg = glyph(m_disp % 10);
      else if (d_sel == 1) e_seg = (m_disp / 10 == 0) ? 7'h7F : glyph(m_disp / 10);
      else                 e_seg = 7'h7F;
      if (m_timer == 0) begin
        if (m_cap != m_src) begin
          m_src = m_cap;
          m_snap = m_cap;
          m_timer = 7;
        end
      end else begin
        m_timer = m_timer - 1;
        if (m_timer == 0) m_disp = m_snap;
      end
      m_cap   = int'(score);
      m_scan  = (m_scan + 1) % 16;
      m_blink = colision ? (m_blink + 1) % 32 : 0;
    end
    #1;
    checks++;
    if (an !== e_an) begin
      errors++;
      $display("FAIL mon_an t=%0t got=%b exp=%b", $time, an, e_an);
    end
    checks++;
    if (dp !== 1'b1) begin
      errors++;
      $display("FAIL mon_dp t=%0t got=%b exp=1", $time, dp);
    end
    if (e_an != 4'hF) begin
      checks++;
      if (seg !== e_seg) begin
        errors++;
        $display("FAIL mon_seg t=%0t an=%b got=%b exp=%b disp=%0d", $time, an, seg, e_seg, m_disp);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_an(input logic [3:0] pat, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if (an === pat) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset;
    bit ok;
    reset = 1'b0;
    score = 6'd0;
    step(3);
    checks++;
    if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
    checks++;
    if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
    checks++;
    if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
    reset = 1'b1;
    wait_an(4'b1110, ok);
    checks++;
    if (!ok || seg !== 7'b1000000) begin errors++; $display("FAIL reset_units ok=%0d got=%b exp=1000000", ok, seg); end
    wait_an(4'b1101, ok);
    checks++;
    if (!ok || seg !== 7'h7F) begin errors++; $display("FAIL reset_tens ok=%0d got=%b exp=1111111", ok, seg); end
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_convert;
    bit ok;
    score = 6'd37;
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (an === 4'b1110) begin
        checks++;
        if (seg !== 7'b1000000) begin errors++; $display("FAIL conv_early cyc=%0d got=%b exp=1000000", i + 1, seg); end
      end
    end
    wait_an(4'b1110, ok);
    checks++;
    if (!ok || seg !== 7'b1111000) begin errors++; $display("FAIL conv37_units ok=%0d got=%b exp=1111000", ok, seg); end
    wait_an(4'b1101, ok);
    checks++;
    if (!ok || seg !== 7'b0110000) begin errors++; $display("FAIL conv37_tens ok=%0d got=%b exp=0110000", ok, seg); end
    $display("test_convert score=37 checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_boundary;
    bit ok;
    score = 6'd63;
    step(12);
    wait_an(4'b1110, ok);
    checks++;
    if (!ok || seg !== 7'b0110000) begin errors++; $display("FAIL b63_units ok=%0d got=%b exp=0110000", ok, seg); end
    wait_an(4'b1101, ok);
    checks++;
    if (!ok || seg !== 7'b0000010) begin errors++; $display("FAIL b63_tens ok=%0d got=%b exp=0000010", ok, seg); end
    score = 6'd9;
    step(12);
    wait_an(4'b1110, ok);
    checks++;
    if (!ok || seg !== 7'b0010000) begin errors++; $display("FAIL b9_units ok=%0d got=%b exp=0010000", ok, seg); end
    wait_an(4'b1101, ok);
    checks++;
    if (!ok || seg !== 7'h7F) begin errors++; $display("FAIL b9_tens ok=%0d got=%b exp=1111111", ok, seg); end
    $display("test_boundary scores=63,9 checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_back_to_back;
    bit ok;
    score = 6'd12;
    step(5);
    score = 6'd45;
    step(25);
    wait_an(4'b1110, ok);
    checks++;
    if (!ok || seg !== 7'b0010010) begin errors++; $display("FAIL b2b_units ok=%0d got=%b exp=0010010", ok, seg); end
    wait_an(4'b1101, ok);
    checks++;
    if (!ok || seg !== 7'b0011001) begin errors++; $display("FAIL b2b_tens ok=%0d got=%b exp=0011001", ok, seg); end
    $display("test_back_to_back scores=12,45 checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_blink;
    int nblank = 0;
    int first = 0;
    colision = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      step(1);
      if (an === 4'hF) begin
        nblank++;
        if (first == 0) first = k;
      end
    end
    colision = 1'b0;
    checks++;
    if (nblank != 32) begin errors++; $display("FAIL blink_count got=%0d exp=32", nblank); end
    checks++;
    if (first != 17) begin errors++; $display("FAIL blink_first got=%0d exp=17", first); end
    step(1);
    checks++;
    if (an === 4'hF) begin errors++; $display("FAIL blink_release got=%b exp=not 1111", an); end
    $display("test_blink blank=%0d first=%0d checks=%0d errors=%0d", nblank, first, checks, errors);
  endtask

  task automatic test_reset_mid_shift;
    bit ok;
    score = 6'd20;
    step(4);
    reset = 1'b0;
    #1;
    checks++;
    if (an !== 4'hF) begin errors++; $display("FAIL rst_mid_an got=%b exp=1111", an); end
    checks++;
    if (seg !== 7'h7F) begin errors++; $display("FAIL rst_mid_seg got=%b exp=1111111", seg); end
    score = 6'd58;
    step(2);
    reset = 1'b1;
    step(12);
    wait_an(4'b1110, ok);
    checks++;
    if (!ok || seg !== 7'b0000000) begin errors++; $display("FAIL rst58_units ok=%0d got=%b exp=0000000", ok, seg); end
    wait_an(4'b1101, ok);
    checks++;
    if (!ok || seg !== 7'b0010010) begin errors++; $display("FAIL rst58_tens ok=%0d got=%b exp=0010010", ok, seg); end
    $display("test_reset_mid_shift score=58 checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random;
    int hold;
    for (int i = 0; i < 25; i++) begin
      score    = 6'($urandom_range(0, 63));
      colision = ($urandom_range(0, 3) == 0);
      hold     = $urandom_range(1, 30);
      step(hold);
      $display("random %0d score=%0d colision=%0d hold=%0d errors=%0d", i, score, colision, hold, errors);
    end
    colision = 1'b0;
    step(20);
  endtask

  initial begin
    test_reset;
    test_convert;
    test_boundary;
    test_back_to_back;
    test_blink;
    test_reset_mid_shift;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
